// File: rtl/systolic_pkg.sv
// Shared types and helpers for the 2x2 systolic matrix-multiply engine.
// Holds the FSM state encoding, datapath widths and the result scaling function.
package systolic_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        COMPUTE,
        OUTPUT,
        DONE
    } state_e;

    localparam int OPW  = 8;
    localparam int PW   = 2 * OPW;
    localparam int ACCW = 2 * OPW + 1;

    localparam logic [3:0] LOAD_LAST = 4'd8;
    localparam logic [3:0] ADDR_LAST = 4'd7;
    localparam logic [3:0] COMP_LAST = 4'd3;

    localparam logic signed [ACCW-1:0] ACC_MAX = 127;
    localparam logic signed [ACCW-1:0] ACC_MIN = -128;
    localparam logic signed [OPW-1:0]  RES_MAX = 127;
    localparam logic signed [OPW-1:0]  RES_MIN = -128;

    // Arithmetic shift then clamp into the int8 range.
    function automatic logic signed [OPW-1:0] sat_shift(input logic signed [ACCW-1:0] acc,
                                                        input int shift);
        logic signed [ACCW-1:0] s;
        s = acc >>> shift;
        if (s > ACC_MAX) begin
            return RES_MAX;
        end else if (s < ACC_MIN) begin
            return RES_MIN;
        end else begin
            return s[OPW-1:0];
        end
    endfunction

endpackage

// File: rtl/systolic_pe.sv
// One processing element: signed multiply-accumulate with registered
// forwarding of the a operand to the right and the b operand downwards.
module systolic_pe
    import systolic_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clr,
    input  logic                   en,
    input  logic signed [OPW-1:0]  a_in,
    input  logic signed [OPW-1:0]  b_in,
    output logic signed [OPW-1:0]  a_out,
    output logic signed [OPW-1:0]  b_out,
    output logic signed [ACCW-1:0] acc
);

    logic signed [OPW-1:0]  a_q, a_d;
    logic signed [OPW-1:0]  b_q, b_d;
    logic signed [ACCW-1:0] acc_q, acc_d;
    logic signed [PW-1:0]   prod;

    always_comb begin
        prod  = PW'(a_in) * PW'(b_in);
        a_d   = a_q;
        b_d   = b_q;
        acc_d = acc_q;
        // Clearing the forwarding registers too keeps stale operands out of the next run.
        if (clr) begin
            a_d   = '0;
            b_d   = '0;
            acc_d = '0;
        end else if (en) begin
            a_d   = a_in;
            b_d   = b_in;
            acc_d = acc_q + ACCW'(prod);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q   <= '0;
            b_q   <= '0;
            acc_q <= '0;
        end else begin
            a_q   <= a_d;
            b_q   <= b_d;
            acc_q <= acc_d;
        end
    end

    assign a_out = a_q;
    assign b_out = b_q;
    assign acc   = acc_q;

endmodule

// File: rtl/systolic_matmul_2x2.sv
// 2x2 signed int8 matrix multiply: loads A and B from a registered-read register
// file, runs an output-stationary systolic array, streams saturated results out.
module systolic_matmul_2x2
    import systolic_pkg::*;
#(
    parameter int W      = 8,
    parameter int ADDR_W = 7,
    parameter int BASE_A = 0,
    parameter int BASE_B = 4,
    parameter int SHIFT  = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [W-1:0]      rd_data,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [W-1:0]      res_data,
    output logic [1:0]        res_idx
);

    state_e                   state_q, state_d;
    logic [3:0]               cnt_q, cnt_d;
    logic [ADDR_W-1:0]        rd_addr_q, rd_addr_d;
    logic signed [W-1:0]      op_q [8];
    logic signed [W-1:0]      op_d [8];
    logic                     res_valid_q, res_valid_d;
    logic [W-1:0]             res_data_q, res_data_d;
    logic [1:0]               res_idx_q, res_idx_d;

    logic                     pe_clr, pe_en;
    logic signed [W-1:0]      a_left [2];
    logic signed [W-1:0]      b_top [2];
    logic signed [W-1:0]      a_01, a_11, b_10, b_11;
    logic signed [W-1:0]      a_unused_0, a_unused_1, b_unused_0, b_unused_1;
    logic signed [ACCW-1:0]   acc_w [4];

    // Operand slot n: 0..3 are A row-major, 4..7 are B row-major.
    function automatic logic [ADDR_W-1:0] addr_of(input logic [3:0] n);
        if (n < 4'd4) begin
            return ADDR_W'(BASE_A) + ADDR_W'(n);
        end else begin
            return ADDR_W'(BASE_B) + ADDR_W'(n - 4'd4);
        end
    endfunction

    assign pe_clr = (state_q == IDLE) && start;
    assign pe_en  = (state_q == COMPUTE);

    // Skewed feed: row i of A lags by i cycles, column j of B lags by j cycles.
    always_comb begin
        a_left[0] = '0;
        a_left[1] = '0;
        b_top[0]  = '0;
        b_top[1]  = '0;
        if (state_q == COMPUTE) begin
            case (cnt_q[1:0])
                2'd0: begin
                    a_left[0] = op_q[0];
                    b_top[0]  = op_q[4];
                end
                2'd1: begin
                    a_left[0] = op_q[1];
                    a_left[1] = op_q[2];
                    b_top[0]  = op_q[6];
                    b_top[1]  = op_q[5];
                end
                2'd2: begin
                    a_left[1] = op_q[3];
                    b_top[1]  = op_q[7];
                end
                default: ;
            endcase
        end
    end

    systolic_pe u_pe00 (
        .clk(clk), .rst_n(rst_n), .clr(pe_clr), .en(pe_en),
        .a_in(a_left[0]), .b_in(b_top[0]), .a_out(a_01), .b_out(b_10), .acc(acc_w[0])
    );
    systolic_pe u_pe01 (
        .clk(clk), .rst_n(rst_n), .clr(pe_clr), .en(pe_en),
        .a_in(a_01), .b_in(b_top[1]), .a_out(a_unused_0), .b_out(b_11), .acc(acc_w[1])
    );
    systolic_pe u_pe10 (
        .clk(clk), .rst_n(rst_n), .clr(pe_clr), .en(pe_en),
        .a_in(a_left[1]), .b_in(b_10), .a_out(a_11), .b_out(b_unused_0), .acc(acc_w[2])
    );
    systolic_pe u_pe11 (
        .clk(clk), .rst_n(rst_n), .clr(pe_clr), .en(pe_en),
        .a_in(a_11), .b_in(b_11), .a_out(a_unused_1), .b_out(b_unused_1), .acc(acc_w[3])
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rd_addr_d   = rd_addr_q;
        op_d        = op_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        res_idx_d   = res_idx_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = LOAD;
                    cnt_d     = '0;
                    rd_addr_d = addr_of(4'd0);
                end
            end
            LOAD: begin
                // Read data trails its address by one cycle, so slot cnt-1 lands now.
                if (cnt_q != 4'd0) begin
                    op_d[3'(cnt_q - 4'd1)] = rd_data;
                end
                if (cnt_q < ADDR_LAST) begin
                    rd_addr_d = addr_of(cnt_q + 4'd1);
                end
                if (cnt_q == LOAD_LAST) begin
                    state_d = COMPUTE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            COMPUTE: begin
                if (cnt_q == COMP_LAST) begin
                    state_d = OUTPUT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            OUTPUT: begin
                if (!res_valid_q) begin
                    res_valid_d = 1'b1;
                    res_idx_d   = 2'd0;
                    res_data_d  = sat_shift(acc_w[0], SHIFT);
                end else if (res_ready) begin
                    if (res_idx_q == 2'd3) begin
                        res_valid_d = 1'b0;
                        state_d     = DONE;
                    end else begin
                        res_idx_d  = res_idx_q + 2'd1;
                        res_data_d = sat_shift(acc_w[res_idx_q + 2'd1], SHIFT);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rd_addr_q   <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_idx_q   <= '0;
            for (int i = 0; i < 8; i++) begin
                op_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rd_addr_q   <= rd_addr_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_idx_q   <= res_idx_d;
            for (int i = 0; i < 8; i++) begin
                op_q[i] <= op_d[i];
            end
        end
    end

    assign busy      = (state_q == LOAD) || (state_q == COMPUTE) || (state_q == OUTPUT);
    assign done      = (state_q == DONE);
    assign rd_addr   = rd_addr_q;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_idx   = res_idx_q;

endmodule

// File: tb/tb_systolic_matmul_2x2.sv
// Scoreboard bench for the 2x2 systolic multiplier: directed matrices with
// hand-computed products, stall, ignored-start and mid-run reset scenarios.
module tb_systolic_matmul_2x2;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       busy;
    logic       done;
    logic [6:0] rd_addr;
    logic [7:0] rd_data;
    logic       res_valid;
    logic       res_ready;
    logic [7:0] res_data;
    logic [1:0] res_idx;

    logic [7:0] mem [0:127];
    logic [9:0] exp_q[$];

    int n_checks;
    int n_errors;
    int cyc;
    int hs_cnt;
    int done_cnt;
    int done_cyc;
    int last_hs_cyc;
    int hs0;
    int d0;
    logic       ready_mode;
    logic [3:0] ready_pat;
    logic       hold_pend;
    logic [9:0] hold_val;

    systolic_matmul_2x2 dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .busy(busy),
        .done(done),
        .rd_addr(rd_addr),
        .rd_data(rd_data),
        .res_valid(res_valid),
        .res_ready(res_ready),
        .res_data(res_data),
        .res_idx(res_idx)
    );

    // ---------------- clock / reset / environment ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        rd_data <= mem[rd_addr];
        cyc     <= cyc + 1;
    end

    initial begin
        int k;
        k = 0;
        res_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            res_ready = ready_mode ? ready_pat[k[1:0]] : 1'b1;
            k = k + 1;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on each handshake and checks stall stability.
    always @(negedge clk) begin
        if (rst_n) begin
            if (hold_pend) begin
                check("stall_hold", {22'd0, res_valid, res_idx, res_data}, {22'd0, 1'b1, hold_val});
            end
            if (res_valid && res_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_result", {22'd0, res_idx, res_data}, 32'hFFFF_FFFF);
                end else begin
                    check("result", {22'd0, res_idx, res_data}, {22'd0, exp_q.pop_front()});
                end
                hs_cnt++;
                if (res_idx == 2'd3) last_hs_cyc = cyc;
            end
            hold_pend = res_valid && !res_ready;
            hold_val  = {res_idx, res_data};
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end else begin
            hold_pend = 1'b0;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic load_mats(input logic [7:0] a0, a1, a2, a3, b0, b1, b2, b3);
        mem[0] = a0; mem[1] = a1; mem[2] = a2; mem[3] = a3;
        mem[4] = b0; mem[5] = b1; mem[6] = b2; mem[7] = b3;
    endtask

    task automatic push_exp(input logic [7:0] c0, c1, c2, c3);
        exp_q.push_back({2'd0, c0});
        exp_q.push_back({2'd1, c1});
        exp_q.push_back({2'd2, c2});
        exp_q.push_back({2'd3, c3});
    endtask

    // Leaves the caller 1 time unit after the start-sampling edge (edge 0).
    task automatic do_start();
        @(posedge clk);
        #1;
        hs0 = hs_cnt;
        d0  = done_cnt;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic run_timed(input string tag);
        do_start();
        for (int e = 0; e <= 14; e++) begin
            @(negedge clk);
            if (e == 0) check({tag, "_busy_rise"}, {31'd0, busy}, 32'd1);
            if (e <= 9) check({tag, "_rd_addr"}, {25'd0, rd_addr}, (e < 7) ? e : 7);
            if (e == 13) check({tag, "_valid_edge13"}, {31'd0, res_valid}, 32'd0);
            if (e == 14) check({tag, "_valid_edge14"}, {31'd0, res_valid}, 32'd1);
            if (e < 14) @(posedge clk);
        end
    endtask

    task automatic finish_run(input string tag);
        for (int i = 0; i < 100 && done_cnt == d0; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        check({tag, "_done_count"}, done_cnt - d0, 32'd1);
        check({tag, "_handshakes"}, hs_cnt - hs0, 32'd4);
        check({tag, "_queue_empty"}, exp_q.size(), 32'd0);
        check({tag, "_done_after_last"}, done_cyc, last_hs_cyc + 1);
        check({tag, "_busy_low"}, {31'd0, busy}, 32'd0);
        exp_q.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_done"}, {31'd0, done}, 32'd0);
        check({tag, "_res_valid"}, {31'd0, res_valid}, 32'd0);
        check({tag, "_res_data"}, {24'd0, res_data}, 32'd0);
        check({tag, "_res_idx"}, {30'd0, res_idx}, 32'd0);
        check({tag, "_rd_addr"}, {25'd0, rd_addr}, 32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        n_checks = 0; n_errors = 0; cyc = 0;
        hs_cnt = 0; done_cnt = 0; done_cyc = -1; last_hs_cyc = -1;
        hs0 = 0; d0 = 0;
        ready_mode = 1'b0; ready_pat = 4'b1001;
        hold_pend = 1'b0; hold_val = '0;
        rst_n = 1'b0; start = 1'b0;
        for (int i = 0; i < 128; i++) mem[i] = 8'h00;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;

        // Basic product: [1,2;3,4] * [5,6;7,8] = [19,22;43,50]
        load_mats(8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8);
        push_exp(8'd19, 8'd22, 8'd43, 8'd50);
        run_timed("basic");
        finish_run("basic");

        // 127 * -128 summed twice = -32512 -> -128
        load_mats(8'h7F, 8'h7F, 8'h7F, 8'h7F, 8'h80, 8'h80, 8'h80, 8'h80);
        push_exp(8'h80, 8'h80, 8'h80, 8'h80);
        run_timed("sat_neg");
        finish_run("sat_neg");

        // -128 * -128 summed twice = 32768 -> 127
        load_mats(8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80);
        push_exp(8'h7F, 8'h7F, 8'h7F, 8'h7F);
        run_timed("sat_pos");
        finish_run("sat_pos");

        // Backpressure with ready cycling 1,0,0,1
        load_mats(8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8);
        push_exp(8'd19, 8'd22, 8'd43, 8'd50);
        ready_mode = 1'b1;
        run_timed("stall");
        finish_run("stall");
        ready_mode = 1'b0;

        // start pulses during LOAD and OUTPUT must not restart or duplicate
        push_exp(8'd19, 8'd22, 8'd43, 8'd50);
        do_start();
        repeat (3) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int i = 0; i < 40 && !res_valid; i++) @(negedge clk);
        check("ign_valid_seen", {31'd0, res_valid}, 32'd1);
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        finish_run("ignore_start");
        repeat (20) @(negedge clk);
        check("ign_no_restart_busy", {31'd0, busy}, 32'd0);
        check("ign_single_done", done_cnt - d0, 32'd1);
        check("ign_single_stream", hs_cnt - hs0, 32'd4);

        // Asynchronous reset while in COMPUTE abandons the run
        load_mats(8'hFF, 8'd2, 8'd3, 8'hFC, 8'd5, 8'hFA, 8'd7, 8'd8);
        do_start();
        repeat (11) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (25) @(negedge clk);
        check("async_rst_no_done", done_cnt - d0, 32'd0);
        check("async_rst_no_results", hs_cnt - hs0, 32'd0);

        // Fresh run after reset: [-1,2;3,-4] * [5,-6;7,8] = [9,22;-13,-50]
        push_exp(8'd9, 8'd22, 8'hF3, 8'hCE);
        run_timed("post_rst");
        finish_run("post_rst");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
